// File: rtl/bios_boot_watchdog_pkg.sv
// bios_boot_watchdog_pkg
// Shared definitions for the BIOS boot watchdog: register map on the CPLD
// register bus, CTRL bit positions, FSM state encodings and a helper that
// turns the programmed timeout into a counter load value.
package bios_boot_watchdog_pkg;

  localparam logic [7:0] WDT_CTRL    = 8'h05;
  localparam logic [7:0] WDT_TIMEOUT = 8'h06;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_KICK_BIT     = 1;
  localparam int CTRL_BOOTDONE_BIT = 2;

  // Both flash parts have been tried once Attempt reaches this value.
  localparam logic [1:0] ATTEMPT_MAX = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    RESET     = 3'd2,
    WAIT_BOOT = 3'd3,
    DONE      = 3'd4,
    LOCKED    = 3'd5
  } wdtState;

  // A zero timeout would never expire, so it is promoted to one unit.
  function automatic logic [7:0] loadValue(input logic [7:0] timeoutUnits);
    return (timeoutUnits == 8'd0) ? 8'd1 : timeoutUnits;
  endfunction

endpackage

// File: rtl/bios_boot_watchdog_if.sv
// bios_boot_watchdog_if
// Write side of the shared CPLD register bus as seen by the watchdog.
//   Write      : one-cycle register write strobe
//   RegAddress : 8-bit register address
//   DataWr     : 8-bit write data
// master drives the bus, slave (the watchdog) only observes it.
interface bios_boot_watchdog_if;
  logic       Write;
  logic [7:0] RegAddress;
  logic [7:0] DataWr;

  modport master (output Write, RegAddress, DataWr);
  modport slave  (input  Write, RegAddress, DataWr);
endinterface

// File: rtl/wdt_prescaler.sv
// wdt_prescaler
// Divides LpcClock down to timeout units for the boot watchdog.
//   LpcClock : clock
//   ResetN   : asynchronous active-low reset
//   clear    : synchronous clear of the divider (wins over enable)
//   enable   : divider advances only while high
//   tick     : one-cycle pulse in the cycle the divider sits at TICK_DIV-1
module wdt_prescaler #(
  parameter logic [23:0] TICK_DIV = 24'd8_448_000
) (
  input  logic LpcClock,
  input  logic ResetN,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [23:0] count;

  // The tick is decoded from the current count so the watchdog FSM can act on
  // it in the same cycle the divider wraps.
  assign tick = enable && (count == TICK_DIV - 24'd1);

  // Divider register: clear has priority, then wrap on tick, else count up.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 24'd1;
    end
  end

endmodule

// File: rtl/bios_boot_watchdog.sv
// bios_boot_watchdog
// Watches each platform boot and drives the dual-BIOS swap when the host
// never reports boot-done. After both flash parts fail it locks up with a
// failure flag instead of swapping forever.
//   LpcClock    : 33 MHz clock, all logic on its rising edge
//   ResetN      : power reset, asynchronous active-low
//   MainReset   : platform reset, low = in reset, rising edge = boot start
//   regBus      : CPLD register bus write port (CTRL 0x05, TIMEOUT 0x06)
//   SwapDisable : high = an expiry must not request a BIOS swap
//   ForceSwap   : one-cycle swap request, 01 first failure, 10 second
//   RstReqN     : active-low platform reset request pulse
//   WdtStatus   : {WdtFail, Armed, Attempt[1:0]}
module bios_boot_watchdog
  import bios_boot_watchdog_pkg::*;
#(
  parameter logic [23:0] TICK_DIV    = 24'd8_448_000,
  parameter logic [7:0]  TIMEOUT_DEF = 8'd117,
  parameter logic [15:0] RST_CYCLES  = 16'd3300,
  parameter logic        ENABLE_DEF  = 1'b1
) (
  input  logic                        LpcClock,
  input  logic                        ResetN,
  input  logic                        MainReset,
  bios_boot_watchdog_if.slave         regBus,
  input  logic                        SwapDisable,
  output logic [1:0]                  ForceSwap,
  output logic                        RstReqN,
  output logic [3:0]                  WdtStatus
);

  wdtState     state;
  wdtState     nextState;

  logic        mainCur;
  logic        mainPrev;
  logic        rise;
  logic        mainLow;

  logic        enableReg;
  logic [7:0]  timeoutReg;

  logic        ctrlWr;
  logic        timeoutWr;
  logic        kick;
  logic        bootDone;
  logic        disableWr;

  logic [7:0]  counter;
  logic [1:0]  attempt;
  logic        wdtFail;
  logic [15:0] rstCount;

  logic        presClear;
  logic        presEnable;
  logic        presTick;

  logic        loadCnt;
  logic        decCnt;
  logic        failSwap;
  logic        failLock;
  logic        clearAttempt;
  logic        clearFail;
  logic        armed;

  // Register bus decode; Kick and BootDone are strobes and never stored.
  assign ctrlWr    = regBus.Write && (regBus.RegAddress == WDT_CTRL);
  assign timeoutWr = regBus.Write && (regBus.RegAddress == WDT_TIMEOUT);
  assign kick      = ctrlWr && regBus.DataWr[CTRL_KICK_BIT];
  assign bootDone  = ctrlWr && regBus.DataWr[CTRL_BOOTDONE_BIT];
  assign disableWr = ctrlWr && !regBus.DataWr[CTRL_ENABLE_BIT];

  assign rise    = mainCur && !mainPrev;
  assign mainLow = !mainCur;

  // Holding the divider in clear outside ARMED means every arm starts from a
  // full unit; a Kick restarts the current unit as well.
  assign presClear  = (state != ARMED) || kick;
  assign presEnable = (state == ARMED);

  wdt_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) prescaler (
    .LpcClock (LpcClock),
    .ResetN   (ResetN),
    .clear    (presClear),
    .enable   (presEnable),
    .tick     (presTick)
  );

  // Two-flop sampler on MainReset; a boot starts when it is seen going high.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      mainCur  <= 1'b0;
      mainPrev <= 1'b0;
    end else begin
      mainCur  <= MainReset;
      mainPrev <= mainCur;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      enableReg  <= ENABLE_DEF;
      timeoutReg <= TIMEOUT_DEF;
    end else begin
      if (ctrlWr) begin
        enableReg <= regBus.DataWr[CTRL_ENABLE_BIT];
      end
      if (timeoutWr) begin
        timeoutReg <= regBus.DataWr;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Inside ARMED the if-chain order is the priority order:
  // BootDone, disable, external reset, Kick, then the unit tick / expiry.
  always_comb begin
    nextState    = state;
    loadCnt      = 1'b0;
    decCnt       = 1'b0;
    failSwap     = 1'b0;
    failLock     = 1'b0;
    clearAttempt = 1'b0;
    clearFail    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise && enableReg) begin
          nextState = ARMED;
          loadCnt   = 1'b1;
        end
      end
      ARMED: begin
        if (bootDone) begin
          nextState    = DONE;
          clearAttempt = 1'b1;
        end else if (disableWr) begin
          nextState = IDLE;
        end else if (mainLow) begin
          nextState = WAIT_BOOT;
        end else if (kick) begin
          loadCnt = 1'b1;
        end else if (presTick) begin
          if (counter <= 8'd1) begin
            if (attempt < ATTEMPT_MAX) begin
              nextState = RESET;
              failSwap  = 1'b1;
            end else begin
              nextState = LOCKED;
              failLock  = 1'b1;
            end
          end else begin
            decCnt = 1'b1;
          end
        end
      end
      RESET: begin
        if (rstCount == RST_CYCLES - 16'd1) begin
          nextState = WAIT_BOOT;
        end
      end
      WAIT_BOOT: begin
        if (bootDone) begin
          nextState    = DONE;
          clearAttempt = 1'b1;
        end else if (rise) begin
          nextState = ARMED;
          loadCnt   = 1'b1;
        end
      end
      DONE: begin
        if (rise && enableReg) begin
          nextState = ARMED;
          loadCnt   = 1'b1;
        end
      end
      LOCKED: begin
        if (bootDone) begin
          nextState    = DONE;
          clearAttempt = 1'b1;
          clearFail    = 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Watchdog datapath: timeout counter, attempt tracking, failure flag,
  // reset-pulse timer and the registered single-cycle ForceSwap.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      counter   <= '0;
      attempt   <= '0;
      wdtFail   <= 1'b0;
      rstCount  <= '0;
      ForceSwap <= 2'b00;
    end else begin
      ForceSwap <= 2'b00;
      if (loadCnt) begin
        counter <= loadValue(timeoutReg);
      end else if (decCnt) begin
        counter <= counter - 8'd1;
      end
      if (failSwap) begin
        attempt <= attempt + 2'd1;
        if (!SwapDisable) begin
          ForceSwap <= (attempt == 2'd0) ? 2'b01 : 2'b10;
        end
      end
      if (failLock) begin
        wdtFail <= 1'b1;
      end
      if (clearAttempt) begin
        attempt <= '0;
      end
      if (clearFail) begin
        wdtFail <= 1'b0;
      end
      rstCount <= (state == RESET) ? rstCount + 16'd1 : 16'd0;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    armed     = (state == ARMED);
    RstReqN   = (state != RESET);
    WdtStatus = {wdtFail, armed, attempt};
  end

endmodule

// File: tb/tb_bios_boot_watchdog.sv
// tb_bios_boot_watchdog
// Directed bench for bios_boot_watchdog with a short prescaler (4 cycles per
// unit), a 5-cycle reset pulse and Timeout programmed to 3 units.
module tb_bios_boot_watchdog;
  import bios_boot_watchdog_pkg::*;

  localparam logic [23:0] TB_TICK_DIV   = 24'd4;
  localparam logic [15:0] TB_RST_CYCLES = 16'd5;

  logic       LpcClock;
  logic       ResetN;
  logic       MainReset;
  logic       SwapDisable;
  logic [1:0] ForceSwap;
  logic       RstReqN;
  logic [3:0] WdtStatus;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] data;
    logic       mainRst;
    int         cycles;
    logic [1:0] expSwap;
    logic       expRstN;
    logic [3:0] expStatus;
  } vector_t;

  vector_t vectors[19];

  bios_boot_watchdog_if regBus();

  bios_boot_watchdog #(
    .TICK_DIV    (TB_TICK_DIV),
    .TIMEOUT_DEF (8'd117),
    .RST_CYCLES  (TB_RST_CYCLES),
    .ENABLE_DEF  (1'b1)
  ) dut (
    .LpcClock    (LpcClock),
    .ResetN      (ResetN),
    .MainReset   (MainReset),
    .regBus      (regBus),
    .SwapDisable (SwapDisable),
    .ForceSwap   (ForceSwap),
    .RstReqN     (RstReqN),
    .WdtStatus   (WdtStatus)
  );

  // 33 MHz-style free-running clock (period 10 time units).
  initial begin
    LpcClock = 1'b0;
    forever #5 LpcClock = ~LpcClock;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic stepClk();
    @(posedge LpcClock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic regWrite(input logic [7:0] addr, input logic [7:0] data);
    regBus.Write      = 1'b1;
    regBus.RegAddress = addr;
    regBus.DataWr     = data;
    stepClk();
    regBus.Write      = 1'b0;
  endtask

  task automatic applyStimulus(input vector_t v);
    MainReset = v.mainRst;
    for (int c = 0; c < v.cycles; c++) begin
      if (c == 0 && v.write) begin
        regWrite(v.addr, v.data);
      end else begin
        stepClk();
      end
    end
  endtask

  // MainReset low then high; returns just after the edge that arms the FSM.
  task automatic bootRise();
    MainReset = 1'b0;
    stepClk();
    stepClk();
    MainReset = 1'b1;
    stepClk();
    stepClk();
  endtask

  // Runs from just after arming to the expiry edge and through the reset pulse.
  task automatic expiryCheck(input string name, input int steps, input logic [1:0] expSwap,
                             input int expLow, input logic [3:0] expStatus);
    int early;
    int lowCount;
    early    = 0;
    lowCount = 0;
    for (int i = 1; i < steps; i++) begin
      stepClk();
      if (ForceSwap != 2'b00 || !RstReqN) early++;
    end
    checkOutput({name, " early activity"}, early, 0);
    stepClk();
    checkOutput({name, " swap"}, ForceSwap, expSwap);
    if (!RstReqN) lowCount++;
    stepClk();
    checkOutput({name, " swap width"}, ForceSwap, 2'b00);
    for (int k = 0; k < 40 && !RstReqN; k++) begin
      lowCount++;
      stepClk();
    end
    checkOutput({name, " reset width"}, lowCount, expLow);
    checkOutput({name, " status"}, WdtStatus, expStatus);
  endtask

  initial begin
    int bad;
    testsRun    = 0;
    testsFailed = 0;

    //            write addr         data   mRst cyc swap rstN status
    vectors[0]  = '{1'b1, WDT_TIMEOUT, 8'h03, 1'b0, 1,  2'b00, 1'b1, 4'b0000};
    vectors[1]  = '{1'b0, 8'h00,       8'h00, 1'b1, 1,  2'b00, 1'b1, 4'b0000};
    vectors[2]  = '{1'b0, 8'h00,       8'h00, 1'b1, 1,  2'b00, 1'b1, 4'b0100};
    vectors[3]  = '{1'b1, WDT_CTRL,    8'h03, 1'b1, 1,  2'b00, 1'b1, 4'b0100};
    vectors[4]  = '{1'b1, WDT_CTRL,    8'h05, 1'b1, 1,  2'b00, 1'b1, 4'b0000};
    vectors[5]  = '{1'b0, 8'h00,       8'h00, 1'b1, 3,  2'b00, 1'b1, 4'b0000};
    vectors[6]  = '{1'b0, 8'h00,       8'h00, 1'b0, 2,  2'b00, 1'b1, 4'b0000};
    vectors[7]  = '{1'b0, 8'h00,       8'h00, 1'b1, 2,  2'b00, 1'b1, 4'b0100};
    vectors[8]  = '{1'b1, WDT_CTRL,    8'h00, 1'b1, 1,  2'b00, 1'b1, 4'b0000};
    vectors[9]  = '{1'b0, 8'h00,       8'h00, 1'b0, 2,  2'b00, 1'b1, 4'b0000};
    vectors[10] = '{1'b0, 8'h00,       8'h00, 1'b1, 2,  2'b00, 1'b1, 4'b0000};
    vectors[11] = '{1'b1, WDT_CTRL,    8'h01, 1'b1, 1,  2'b00, 1'b1, 4'b0000};
    vectors[12] = '{1'b0, 8'h00,       8'h00, 1'b0, 2,  2'b00, 1'b1, 4'b0000};
    vectors[13] = '{1'b0, 8'h00,       8'h00, 1'b1, 2,  2'b00, 1'b1, 4'b0100};
    vectors[14] = '{1'b0, 8'h00,       8'h00, 1'b0, 2,  2'b00, 1'b1, 4'b0000};
    vectors[15] = '{1'b0, 8'h00,       8'h00, 1'b0, 20, 2'b00, 1'b1, 4'b0000};
    vectors[16] = '{1'b0, 8'h00,       8'h00, 1'b1, 2,  2'b00, 1'b1, 4'b0100};
    vectors[17] = '{1'b1, WDT_CTRL,    8'h05, 1'b1, 1,  2'b00, 1'b1, 4'b0000};
    vectors[18] = '{1'b1, WDT_CTRL,    8'h03, 1'b1, 1,  2'b00, 1'b1, 4'b0000};

    ResetN            = 1'b0;
    MainReset         = 1'b0;
    SwapDisable       = 1'b0;
    regBus.Write      = 1'b0;
    regBus.RegAddress = 8'h00;
    regBus.DataWr     = 8'h00;

    stepClk();
    stepClk();
    checkOutput("reset ForceSwap", ForceSwap, 2'b00);
    checkOutput("reset RstReqN", RstReqN, 1'b1);
    checkOutput("reset WdtStatus", WdtStatus, 4'b0000);
    ResetN = 1'b1;
    stepClk();

    $display("[TB] register and state vectors");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("vec%0d ForceSwap", i), ForceSwap, vectors[i].expSwap);
      checkOutput($sformatf("vec%0d RstReqN", i), RstReqN, vectors[i].expRstN);
      checkOutput($sformatf("vec%0d WdtStatus", i), WdtStatus, vectors[i].expStatus);
    end

    $display("[TB] consecutive boot failures");
    bootRise();
    checkOutput("fail1 armed", WdtStatus, 4'b0100);
    expiryCheck("fail1", 12, 2'b01, 5, 4'b0001);
    bootRise();
    checkOutput("fail2 armed", WdtStatus, 4'b0101);
    expiryCheck("fail2", 12, 2'b10, 5, 4'b0010);
    bootRise();
    expiryCheck("fail3", 12, 2'b00, 0, 4'b1010);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      stepClk();
      if (!RstReqN || ForceSwap != 2'b00) bad++;
    end
    checkOutput("locked quiet", bad, 0);
    bootRise();
    checkOutput("locked ignores rise", WdtStatus, 4'b1010);
    regWrite(WDT_CTRL, 8'h05);
    checkOutput("locked bootdone", WdtStatus, 4'b0000);

    $display("[TB] periodic kick");
    bootRise();
    checkOutput("kick armed", WdtStatus, 4'b0100);
    bad = 0;
    for (int n = 0; n < 13; n++) begin
      for (int i = 0; i < 7; i++) begin
        stepClk();
        if (ForceSwap != 2'b00 || !RstReqN || !WdtStatus[2]) bad++;
      end
      regWrite(WDT_CTRL, 8'h03);
      if (ForceSwap != 2'b00 || !RstReqN || !WdtStatus[2]) bad++;
    end
    checkOutput("kick no expiry", bad, 0);
    regWrite(WDT_CTRL, 8'h05);
    checkOutput("kick then bootdone", WdtStatus, 4'b0000);

    $display("[TB] kick and bootdone on the expiry tick");
    bootRise();
    for (int i = 0; i < 11; i++) stepClk();
    regWrite(WDT_CTRL, 8'h03);
    checkOutput("kick at expiry swap", ForceSwap, 2'b00);
    checkOutput("kick at expiry status", WdtStatus, 4'b0100);
    expiryCheck("kick reload", 12, 2'b01, 5, 4'b0001);
    bootRise();
    for (int i = 0; i < 11; i++) stepClk();
    regWrite(WDT_CTRL, 8'h05);
    checkOutput("bootdone at expiry swap", ForceSwap, 2'b00);
    checkOutput("bootdone at expiry status", WdtStatus, 4'b0000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      stepClk();
      if (!RstReqN || ForceSwap != 2'b00) bad++;
    end
    checkOutput("bootdone at expiry quiet", bad, 0);

    $display("[TB] swap disable and zero timeout");
    SwapDisable = 1'b1;
    bootRise();
    expiryCheck("swapDisable", 12, 2'b00, 5, 4'b0001);
    SwapDisable = 1'b0;
    regWrite(WDT_TIMEOUT, 8'h00);
    bootRise();
    expiryCheck("timeoutZero", 4, 2'b10, 5, 4'b0010);

    $display("[TB] power reset during reset pulse");
    regWrite(WDT_CTRL, 8'h05);
    checkOutput("pre-reset bootdone", WdtStatus, 4'b0000);
    bootRise();
    for (int i = 0; i < 4; i++) stepClk();
    checkOutput("midreset swap", ForceSwap, 2'b01);
    stepClk();
    stepClk();
    checkOutput("midreset RstReqN low", RstReqN, 1'b0);
    #3;
    ResetN    = 1'b0;
    MainReset = 1'b0;
    #1;
    checkOutput("async RstReqN", RstReqN, 1'b1);
    checkOutput("async WdtStatus", WdtStatus, 4'b0000);
    checkOutput("async ForceSwap", ForceSwap, 2'b00);
    #2;
    ResetN = 1'b1;
    stepClk();
    bootRise();
    checkOutput("default armed", WdtStatus, 4'b0100);
    expiryCheck("timeoutDefault", 468, 2'b01, 5, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
